// File: rtl/piano_key_encoder_if.sv
// piano_key_encoder_if
// Groups the key inputs and the note outputs of piano_key_encoder.
//   master : key source / tone-generator side (drives keys, reads note outputs)
//   slave  : piano_key_encoder side (reads keys, drives note outputs)
// Signals:
//   keys        raw asynchronous key levels, 1 = pressed
//   octave_up   raise the output one octave (only when OCTAVE_SHIFT_EN is defined)
//   half_period half-period count for the tone generator
//   note_idx    index of the selected key
//   gate        1 = tone generator should sound
//   note_change one-cycle pulse on a new note or a new attack
interface piano_key_encoder_if #(
    parameter int NUM_KEYS      = 8,
    parameter int WIDTH_COUNTER = 10
);
    logic [NUM_KEYS-1:0]      keys;
`ifdef OCTAVE_SHIFT_EN
    logic                     octave_up;
`endif
    logic [WIDTH_COUNTER-1:0] half_period;
    logic [2:0]               note_idx;
    logic                     gate;
    logic                     note_change;

`ifdef OCTAVE_SHIFT_EN
    modport master (
        output keys,
        output octave_up,
        input  half_period,
        input  note_idx,
        input  gate,
        input  note_change
    );
    modport slave (
        input  keys,
        input  octave_up,
        output half_period,
        output note_idx,
        output gate,
        output note_change
    );
`else
    modport master (
        output keys,
        input  half_period,
        input  note_idx,
        input  gate,
        input  note_change
    );
    modport slave (
        input  keys,
        output half_period,
        output note_idx,
        output gate,
        output note_change
    );
`endif
endinterface

// File: rtl/piano_key_encoder.sv
// piano_key_encoder
// Front end of the tone generators. Each raw key is synchronized (2 flops) and
// debounced; the highest-index accepted key selects a note from a fixed table,
// and a small FSM produces the gate, holding the last note for RELEASE_CYCLES
// after all keys are lifted.
// Ports:
//   clk  system clock
//   rst  synchronous, active-high reset
//   kbd  piano_key_encoder_if.slave: keys in; half_period, note_idx, gate,
//        note_change out (all registered)
// Optional feature macro: OCTAVE_SHIFT_EN
//   defined   : kbd.octave_up (synchronized) halves the table half-period; a
//               change of octave while playing reloads and pulses note_change
//   undefined : half_period is always the table value
module piano_key_encoder #(
    parameter int NUM_KEYS        = 8,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int WIDTH_DEB       = 10,
    parameter int RELEASE_CYCLES  = 500,
    parameter int WIDTH_COUNTER   = 10
) (
    input  logic              clk,
    input  logic              rst,
    piano_key_encoder_if.slave kbd
);

    // Only the first eight keys have a note in the table.
    localparam int NOTE_KEYS = (NUM_KEYS < 8) ? NUM_KEYS : 8;
    localparam int WIDTH_REL = (RELEASE_CYCLES > 2) ? $clog2(RELEASE_CYCLES) : 1;

    localparam logic [WIDTH_DEB-1:0] DEB_LAST = WIDTH_DEB'(DEBOUNCE_CYCLES - 1);
    localparam logic [WIDTH_REL-1:0] REL_LAST =
        WIDTH_REL'((RELEASE_CYCLES > 0) ? (RELEASE_CYCLES - 1) : 0);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PLAY    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    // Fixed half-period table, one entry per key index.
    function automatic logic [WIDTH_COUNTER-1:0] note_half_period(input logic [2:0] idx);
        logic [9:0] hp;
        case (idx)
            3'd0:    hp = 10'd478;
            3'd1:    hp = 10'd426;
            3'd2:    hp = 10'd379;
            3'd3:    hp = 10'd358;
            3'd4:    hp = 10'd319;
            3'd5:    hp = 10'd284;
            3'd6:    hp = 10'd253;
            3'd7:    hp = 10'd239;
            default: hp = 10'd478;
        endcase
        return WIDTH_COUNTER'(hp);
    endfunction

    logic [NUM_KEYS-1:0]                key_sync1_r;
    logic [NUM_KEYS-1:0]                key_sync2_r;
    logic [NUM_KEYS-1:0]                deb_r;
    logic [NUM_KEYS-1:0][WIDTH_DEB-1:0] deb_cnt_r;

    logic                     any_key_s;
    logic [2:0]               winner_s;
    logic [WIDTH_COUNTER-1:0] hp_target_s;
    logic                     octave_changed_s;
    logic                     load_s;

    state_t                   state_r;
    state_t                   state_next_s;
    logic [WIDTH_REL-1:0]     rel_cnt_r;
    logic [WIDTH_REL-1:0]     rel_cnt_next_s;
    logic [WIDTH_COUNTER-1:0] half_period_r;
    logic [WIDTH_COUNTER-1:0] half_period_next_s;
    logic [2:0]               note_idx_r;
    logic [2:0]               note_idx_next_s;
    logic                     gate_r;
    logic                     gate_next_s;
    logic                     note_change_r;
    logic                     note_change_next_s;

    // Two-flop synchronizer for the raw key levels.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_sync1_r <= '0;
            key_sync2_r <= '0;
        end else begin
            key_sync1_r <= kbd.keys;
            key_sync2_r <= key_sync1_r;
        end
    end

    // Per-key debounce: a differing level must persist DEBOUNCE_CYCLES samples
    // (counter reaches DEB_LAST while still differing) before it is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            deb_r     <= '0;
            deb_cnt_r <= '0;
        end else begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (key_sync2_r[i] == deb_r[i]) begin
                    deb_cnt_r[i] <= '0;
                end else if (deb_cnt_r[i] == DEB_LAST) begin
                    deb_r[i]     <= key_sync2_r[i];
                    deb_cnt_r[i] <= '0;
                end else begin
                    deb_cnt_r[i] <= deb_cnt_r[i] + WIDTH_DEB'(1);
                end
            end
        end
    end

    // Highest-index accepted key wins; later iterations override earlier ones.
    always_comb begin
        any_key_s = 1'b0;
        winner_s  = 3'd0;
        for (int i = 0; i < NOTE_KEYS; i++) begin
            any_key_s = any_key_s | deb_r[i];
            winner_s  = deb_r[i] ? 3'(i) : winner_s;
        end
    end

`ifdef OCTAVE_SHIFT_EN
    logic oct_sync1_r;
    logic oct_sync2_r;
    logic oct_loaded_r;

    // Two-flop synchronizer for octave_up.
    always_ff @(posedge clk) begin
        if (rst) begin
            oct_sync1_r <= 1'b0;
            oct_sync2_r <= 1'b0;
        end else begin
            oct_sync1_r <= kbd.octave_up;
            oct_sync2_r <= oct_sync1_r;
        end
    end

    // Octave setting that the currently output half_period was built with.
    always_ff @(posedge clk) begin
        if (rst) begin
            oct_loaded_r <= 1'b0;
        end else if (load_s) begin
            oct_loaded_r <= oct_sync2_r;
        end else begin
            oct_loaded_r <= oct_loaded_r;
        end
    end

    // Table value, halved when the octave is raised.
    always_comb begin
        if (oct_sync2_r) begin
            hp_target_s = note_half_period(winner_s) >> 1;
        end else begin
            hp_target_s = note_half_period(winner_s);
        end
        octave_changed_s = (oct_sync2_r != oct_loaded_r);
    end
`else
    // Table value used as-is.
    always_comb begin
        hp_target_s      = note_half_period(winner_s);
        octave_changed_s = 1'b0;
    end
`endif

    // Next-state and next-output logic; load_s marks any (re)attack or note switch.
    always_comb begin
        state_next_s       = state_r;
        rel_cnt_next_s     = rel_cnt_r;
        half_period_next_s = half_period_r;
        note_idx_next_s    = note_idx_r;
        gate_next_s        = gate_r;
        note_change_next_s = 1'b0;
        load_s             = 1'b0;
        case (state_r)
            ST_IDLE: begin
                gate_next_s = 1'b0;
                if (any_key_s) begin
                    state_next_s = ST_PLAY;
                    load_s       = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_PLAY: begin
                gate_next_s = 1'b1;
                if (any_key_s) begin
                    if ((winner_s != note_idx_r) || octave_changed_s) begin
                        load_s = 1'b1;
                    end else begin
                        load_s = 1'b0;
                    end
                end else if (RELEASE_CYCLES == 0) begin
                    state_next_s = ST_IDLE;
                    gate_next_s  = 1'b0;
                end else begin
                    state_next_s   = ST_RELEASE;
                    rel_cnt_next_s = '0;
                end
            end
            ST_RELEASE: begin
                gate_next_s = 1'b1;
                if (any_key_s) begin
                    // Any press re-attacks, even the key that was just released.
                    state_next_s = ST_PLAY;
                    load_s       = 1'b1;
                end else if (rel_cnt_r == REL_LAST) begin
                    state_next_s = ST_IDLE;
                    gate_next_s  = 1'b0;
                end else begin
                    rel_cnt_next_s = rel_cnt_r + WIDTH_REL'(1);
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                gate_next_s  = 1'b0;
            end
        endcase
        if (load_s) begin
            half_period_next_s = hp_target_s;
            note_idx_next_s    = winner_s;
            gate_next_s        = 1'b1;
            note_change_next_s = 1'b1;
        end else begin
            note_change_next_s = 1'b0;
        end
    end

    // FSM state and release counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            rel_cnt_r <= '0;
        end else begin
            state_r   <= state_next_s;
            rel_cnt_r <= rel_cnt_next_s;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            half_period_r <= '0;
            note_idx_r    <= 3'd0;
            gate_r        <= 1'b0;
            note_change_r <= 1'b0;
        end else begin
            half_period_r <= half_period_next_s;
            note_idx_r    <= note_idx_next_s;
            gate_r        <= gate_next_s;
            note_change_r <= note_change_next_s;
        end
    end

    assign kbd.half_period = half_period_r;
    assign kbd.note_idx    = note_idx_r;
    assign kbd.gate        = gate_r;
    assign kbd.note_change = note_change_r;

endmodule

// File: tb/tb_piano_key_encoder.sv
// tb_piano_key_encoder
// Directed test of piano_key_encoder with DEBOUNCE_CYCLES=4, RELEASE_CYCLES=10.
// Keys are driven 1 ns after a rising edge; outputs are sampled 1 ns after a
// rising edge. Observed outputs are packed as {gate, note_change, note_idx, half_period}.
module tb_piano_key_encoder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests_run    = 0;
    int   tests_failed = 0;

    logic [14:0] obs;
    logic [14:0] exp_v;

    piano_key_encoder_if #(.NUM_KEYS(8), .WIDTH_COUNTER(10)) kbd_if ();

    piano_key_encoder #(
        .NUM_KEYS        (8),
        .DEBOUNCE_CYCLES (4),
        .WIDTH_DEB       (3),
        .RELEASE_CYCLES  (10),
        .WIDTH_COUNTER   (10)
    ) dut (
        .clk (clk),
        .rst (rst),
        .kbd (kbd_if)
    );

    always #5 clk = ~clk;

    assign obs = {kbd_if.gate, kbd_if.note_change, kbd_if.note_idx, kbd_if.half_period};

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        kbd_if.keys = 8'hFF;
        step(3);
        exp_v = 15'd0;
        tests_run++;
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL reset_hold: got gate=%b nc=%b idx=%0d hp=%0d, expected all 0",
                     obs[14], obs[13], obs[12:10], obs[9:0]);
        end
        rst = 1'b0;
        kbd_if.keys = 8'h00;
        step(20);
        tests_run++;
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL reset_release_idle: got gate=%b nc=%b idx=%0d hp=%0d, expected all 0",
                     obs[14], obs[13], obs[12:10], obs[9:0]);
        end
    endtask

    task automatic test_latency();
        int n;
        kbd_if.keys = 8'h01;
        step(6);
        exp_v = 15'd0;
        tests_run++;
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL latency_early: got gate=%b nc=%b idx=%0d hp=%0d, expected all 0",
                     obs[14], obs[13], obs[12:10], obs[9:0]);
        end
        step(1);
        exp_v = {1'b1, 1'b1, 3'd0, 10'd478};
        tests_run++;
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL latency_attack: got gate=%b nc=%b idx=%0d hp=%0d, expected gate=1 nc=1 idx=0 hp=478",
                     obs[14], obs[13], obs[12:10], obs[9:0]);
        end
        step(1);
        exp_v = {1'b1, 1'b0, 3'd0, 10'd478};
        tests_run++;
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL latency_pulse_end: got gate=%b nc=%b idx=%0d hp=%0d, expected gate=1 nc=0 idx=0 hp=478",
                     obs[14], obs[13], obs[12:10], obs[9:0]);
        end
        kbd_if.keys = 8'h00;
        n = 0;
        while (kbd_if.gate === 1'b1 && n < 40) begin
            step(1);
            n++;
        end
        exp_v = {1'b0, 1'b0, 3'd0, 10'd478};
        tests_run++;
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL latency_return_idle: got gate=%b nc=%b idx=%0d hp=%0d after %0d cycles, expected gate=0 nc=0 idx=0 hp=478",
                     obs[14], obs[13], obs[12:10], obs[9:0], n);
        end
    endtask

    task automatic test_glitch();
        kbd_if.keys = 8'h08;
        step(3);
        kbd_if.keys = 8'h00;
        exp_v = {1'b0, 1'b0, 3'd0, 10'd478};
        for (int i = 0; i < 15; i++) begin
            step(1);
            tests_run++;
            if (obs !== exp_v) begin
                tests_failed++;
                $display("FAIL glitch_reject[%0d]: got gate=%b nc=%b idx=%0d hp=%0d, expected gate=0 nc=0 idx=0 hp=478",
                         i, obs[14], obs[13], obs[12:10], obs[9:0]);
            end
        end
    endtask

    task automatic test_priority();
        kbd_if.keys = 8'h24;
        step(7);
        exp_v = {1'b1, 1'b1, 3'd5, 10'd284};
        tests_run++;
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL priority_attack: got gate=%b nc=%b idx=%0d hp=%0d, expected gate=1 nc=1 idx=5 hp=284",
                     obs[14], obs[13], obs[12:10], obs[9:0]);
        end
        step(3);
        exp_v = {1'b1, 1'b0, 3'd5, 10'd284};
        tests_run++;
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL priority_hold: got gate=%b nc=%b idx=%0d hp=%0d, expected gate=1 nc=0 idx=5 hp=284",
                     obs[14], obs[13], obs[12:10], obs[9:0]);
        end
        kbd_if.keys = 8'h04;
        step(6);
        tests_run++;
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL fallback_early: got gate=%b nc=%b idx=%0d hp=%0d, expected gate=1 nc=0 idx=5 hp=284",
                     obs[14], obs[13], obs[12:10], obs[9:0]);
        end
        step(1);
        exp_v = {1'b1, 1'b1, 3'd2, 10'd379};
        tests_run++;
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL fallback_switch: got gate=%b nc=%b idx=%0d hp=%0d, expected gate=1 nc=1 idx=2 hp=379",
                     obs[14], obs[13], obs[12:10], obs[9:0]);
        end
        step(1);
        exp_v = {1'b1, 1'b0, 3'd2, 10'd379};
        tests_run++;
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL fallback_steady: got gate=%b nc=%b idx=%0d hp=%0d, expected gate=1 nc=0 idx=2 hp=379",
                     obs[14], obs[13], obs[12:10], obs[9:0]);
        end
    endtask

    task automatic test_release_hold();
        kbd_if.keys = 8'h00;
        step(7);
        exp_v = {1'b1, 1'b0, 3'd2, 10'd379};
        tests_run++;
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL release_enter: got gate=%b nc=%b idx=%0d hp=%0d, expected gate=1 nc=0 idx=2 hp=379",
                     obs[14], obs[13], obs[12:10], obs[9:0]);
        end
        step(9);
        tests_run++;
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL release_last_gated: got gate=%b nc=%b idx=%0d hp=%0d, expected gate=1 nc=0 idx=2 hp=379",
                     obs[14], obs[13], obs[12:10], obs[9:0]);
        end
        step(1);
        exp_v = {1'b0, 1'b0, 3'd2, 10'd379};
        tests_run++;
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL release_expire: got gate=%b nc=%b idx=%0d hp=%0d, expected gate=0 nc=0 idx=2 hp=379",
                     obs[14], obs[13], obs[12:10], obs[9:0]);
        end
    endtask

    task automatic test_reattack();
        kbd_if.keys = 8'h40;
        step(7);
        exp_v = {1'b1, 1'b1, 3'd6, 10'd253};
        tests_run++;
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL reattack_first: got gate=%b nc=%b idx=%0d hp=%0d, expected gate=1 nc=1 idx=6 hp=253",
                     obs[14], obs[13], obs[12:10], obs[9:0]);
        end
        step(2);
        kbd_if.keys = 8'h00;
        step(6);
        kbd_if.keys = 8'h40;
        exp_v = {1'b1, 1'b0, 3'd6, 10'd253};
        for (int i = 0; i < 6; i++) begin
            step(1);
            tests_run++;
            if (obs !== exp_v) begin
                tests_failed++;
                $display("FAIL reattack_gate_held[%0d]: got gate=%b nc=%b idx=%0d hp=%0d, expected gate=1 nc=0 idx=6 hp=253",
                         i, obs[14], obs[13], obs[12:10], obs[9:0]);
            end
        end
        step(1);
        exp_v = {1'b1, 1'b1, 3'd6, 10'd253};
        tests_run++;
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL reattack_pulse: got gate=%b nc=%b idx=%0d hp=%0d, expected gate=1 nc=1 idx=6 hp=253",
                     obs[14], obs[13], obs[12:10], obs[9:0]);
        end
        step(1);
        exp_v = {1'b1, 1'b0, 3'd6, 10'd253};
        tests_run++;
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL reattack_after: got gate=%b nc=%b idx=%0d hp=%0d, expected gate=1 nc=0 idx=6 hp=253",
                     obs[14], obs[13], obs[12:10], obs[9:0]);
        end
    endtask

    task automatic test_reset_mid();
        // Key 6 lifted and key 7 pressed in the same cycle.
        kbd_if.keys = 8'h80;
        step(7);
        exp_v = {1'b1, 1'b1, 3'd7, 10'd239};
        tests_run++;
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL swap_to_key7: got gate=%b nc=%b idx=%0d hp=%0d, expected gate=1 nc=1 idx=7 hp=239",
                     obs[14], obs[13], obs[12:10], obs[9:0]);
        end
        step(3);
        rst = 1'b1;
        step(1);
        exp_v = 15'd0;
        tests_run++;
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL reset_mid: got gate=%b nc=%b idx=%0d hp=%0d, expected all 0",
                     obs[14], obs[13], obs[12:10], obs[9:0]);
        end
        rst = 1'b0;
        step(6);
        tests_run++;
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL reset_mid_relatch_early: got gate=%b nc=%b idx=%0d hp=%0d, expected all 0",
                     obs[14], obs[13], obs[12:10], obs[9:0]);
        end
        step(1);
        exp_v = {1'b1, 1'b1, 3'd7, 10'd239};
        tests_run++;
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL reset_mid_relatch: got gate=%b nc=%b idx=%0d hp=%0d, expected gate=1 nc=1 idx=7 hp=239",
                     obs[14], obs[13], obs[12:10], obs[9:0]);
        end
    endtask

    initial begin
        kbd_if.keys = 8'hFF;
`ifdef OCTAVE_SHIFT_EN
        kbd_if.octave_up = 1'b0;
`endif
        test_reset();
        test_latency();
        test_glitch();
        test_priority();
        test_release_hold();
        test_reattack();
        test_reset_mid();
        kbd_if.keys = 8'h00;
        step(5);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
